// File: rtl/alien_pkg.sv
// Geometry and shared types for the alien matrix: used by the matrix mover,
// the draw logic and the shot scheduler.
package alien_pkg;

  localparam int ALIEN_ROW    = 4;
  localparam int ALIEN_COLUMN = 8;
  localparam int ALIEN_W      = 32;
  localparam int ALIEN_H      = 32;

  localparam int ROW_W = (ALIEN_ROW > 1) ? $clog2(ALIEN_ROW) : 1;
  localparam int COL_W = (ALIEN_COLUMN > 1) ? $clog2(ALIEN_COLUMN) : 1;
  localparam int IDX_W = $clog2(ALIEN_ROW * ALIEN_COLUMN);

  typedef enum logic [1:0] {IDLE, WAIT, PICK, ISSUE} sched_state_t;

  // Bit position of alien (r,c) inside the alive mask.
  function automatic int idx(input int r, input int c);
    return r * ALIEN_COLUMN + c;
  endfunction

endpackage

// File: rtl/alien_shot_scheduler_if.sv
// Spawn-request handshake between the shot scheduler (master) and the
// alien missile objects (slave), including the per-slot busy flags.
interface alien_shot_scheduler_if #(
  parameter int NUM_SLOTS = 3
);

  logic                 fireReq;
  logic                 fireAck;
  logic [NUM_SLOTS-1:0] fireSlot;
  logic signed [10:0]   fireX;
  logic signed [10:0]   fireY;
  logic [NUM_SLOTS-1:0] slotBusy;

  modport master (
    output fireReq, fireSlot, fireX, fireY,
    input  fireAck, slotBusy
  );

  modport slave (
    input  fireReq, fireSlot, fireX, fireY,
    output fireAck, slotBusy
  );

endinterface

// File: rtl/alien_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) that advances when en is high.
module alien_lfsr16 (
  input  logic        clk,
  input  logic        resetN,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      q <= seed;
    end else if (en) begin
      q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    end
  end

endmodule

// File: rtl/alien_shot_scheduler.sv
// Decides when the alien matrix fires and from which column; hands the pool of
// missile slots out round-robin over the columns, one spawn request at a time.
module alien_shot_scheduler
  import alien_pkg::*;
#(
  parameter int          NUM_SLOTS     = 3,
  parameter int          BASE_INTERVAL = 45,
  parameter int          MIN_INTERVAL  = 10,
  parameter int          INTERVAL_STEP = 5,
  parameter int          JITTER_BITS   = 4,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                              clk,
  input  logic                              resetN,
  input  logic                              startOfFrame,
  input  logic                              playGame,
  input  logic                              matrixDefeated,
  input  logic [ALIEN_ROW*ALIEN_COLUMN-1:0] aliveMask,
  input  logic signed [10:0]                matrixTopLeftX,
  input  logic signed [10:0]                matrixTopLeftY,
  alien_shot_scheduler_if.master            fire
);

  localparam int INT_W = 8;
  localparam int CNT_W = 17;
  localparam logic [INT_W-1:0] BASE_I = INT_W'(BASE_INTERVAL);
  localparam logic [15:0] JMASK =
    (JITTER_BITS >= 16) ? 16'hFFFF : 16'((32'd1 << JITTER_BITS) - 32'd1);

  sched_state_t         state;
  logic [INT_W-1:0]     curInterval;
  logic [INT_W-1:0]     nextInterval;
  logic [CNT_W-1:0]     frameCnt;
  logic [COL_W-1:0]     rrPtr;
  logic [COL_W-1:0]     scanCol;
  logic [COL_W-1:0]     scanCnt;
  logic [COL_W-1:0]     fireCol;
  logic [15:0]          lfsr;

  logic                 fireReqR;
  logic [NUM_SLOTS-1:0] fireSlotR;
  logic signed [10:0]   fireXR;
  logic signed [10:0]   fireYR;

  logic                 colAlive;
  logic [ROW_W-1:0]     rowSel;
  logic [NUM_SLOTS-1:0] freeOh;
  logic                 anyFree;
  logic [10:0]          xSpawn;
  logic [10:0]          ySpawn;

  function automatic logic [INT_W-1:0] next_interval(input logic [INT_W-1:0] cur);
    int v;
    v = int'(cur) - INTERVAL_STEP;
    if (v < MIN_INTERVAL) v = MIN_INTERVAL;
    return INT_W'(v);
  endfunction

  function automatic logic [CNT_W-1:0] reload_val(input logic [INT_W-1:0] iv,
                                                  input logic [15:0] rnd);
    return CNT_W'(iv) + CNT_W'(rnd & JMASK);
  endfunction

  function automatic logic [COL_W-1:0] next_col(input logic [COL_W-1:0] c);
    return (c == COL_W'(ALIEN_COLUMN - 1)) ? '0 : c + 1'b1;
  endfunction

  alien_lfsr16 u_lfsr (
    .clk    (clk),
    .resetN (resetN),
    .en     (startOfFrame),
    .seed   (LFSR_SEED),
    .q      (lfsr)
  );

  assign nextInterval = next_interval(curInterval);

  // Column under test: lowest alive row wins last, so rowSel ends at the highest.
  always_comb begin
    colAlive = 1'b0;
    rowSel   = '0;
    for (int r = 0; r < ALIEN_ROW; r++) begin
      if (aliveMask[IDX_W'(idx(r, int'(scanCol)))]) begin
        colAlive = 1'b1;
        rowSel   = ROW_W'(r);
      end
    end
    freeOh  = ~fire.slotBusy & (fire.slotBusy + NUM_SLOTS'(1));
    anyFree = ~&fire.slotBusy;
  end

  // Spawn point: centre of the column, just below the chosen alien; 12-bit sum wraps to 11.
  assign xSpawn = 11'({matrixTopLeftX[10], matrixTopLeftX}
                      + 12'(int'(scanCol) * ALIEN_W + ALIEN_W / 2));
  assign ySpawn = 11'({matrixTopLeftY[10], matrixTopLeftY}
                      + 12'((int'(rowSel) + 1) * ALIEN_H));

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= IDLE;
      fireReqR    <= 1'b0;
      fireSlotR   <= '0;
      fireXR      <= '0;
      fireYR      <= '0;
      curInterval <= BASE_I;
      frameCnt    <= '0;
      rrPtr       <= '0;
      scanCol     <= '0;
      scanCnt     <= '0;
      fireCol     <= '0;
    end else if (!playGame) begin
      state       <= IDLE;
      fireReqR    <= 1'b0;
      curInterval <= BASE_I;
      rrPtr       <= '0;
    end else if (matrixDefeated && state != IDLE) begin
      curInterval <= nextInterval;
      rrPtr       <= '0;
      frameCnt    <= reload_val(nextInterval, lfsr);
      fireReqR    <= 1'b0;
      state       <= WAIT;
    end else begin
      case (state)
        IDLE: begin
          frameCnt <= reload_val(curInterval, lfsr);
          state    <= WAIT;
        end
        WAIT: begin
          if (frameCnt != '0) begin
            if (startOfFrame) frameCnt <= frameCnt - 1'b1;
          end else if (anyFree) begin
            scanCol <= rrPtr;
            scanCnt <= '0;
            state   <= PICK;
          end
        end
        PICK: begin
          if (!anyFree) begin
            // Slots filled up mid-scan: counter is still 0, so WAIT retries.
            state <= WAIT;
          end else if (colAlive) begin
            fireSlotR <= freeOh;
            fireXR    <= xSpawn;
            fireYR    <= ySpawn;
            fireCol   <= scanCol;
            fireReqR  <= 1'b1;
            state     <= ISSUE;
          end else if (scanCnt == COL_W'(ALIEN_COLUMN - 1)) begin
            frameCnt <= reload_val(curInterval, lfsr);
            state    <= WAIT;
          end else begin
            scanCol <= next_col(scanCol);
            scanCnt <= scanCnt + 1'b1;
          end
        end
        ISSUE: begin
          if (fire.fireAck) begin
            fireReqR <= 1'b0;
            rrPtr    <= next_col(fireCol);
            frameCnt <= reload_val(curInterval, lfsr);
            state    <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fire.fireReq  = fireReqR;
  assign fire.fireSlot = fireSlotR;
  assign fire.fireX    = fireXR;
  assign fire.fireY    = fireYR;

endmodule
